// File: rtl/tri_bus_pkg.sv
// Shared types and default sizing for the tri-state bus arbiter.
package tri_bus_pkg;

  localparam int N_DEF         = 4;
  localparam int W_DEF         = 16;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from ptr+1 upward (wrapping) and
// returns the first requester found as a one-hot winner.
module rr_pick
  import tri_bus_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          any_req
);

  logic          done;
  logic [PW-1:0] idx;

  // First set bit after ptr wins; ptr itself is checked last
  always_comb begin
    win     = '0;
    done    = 1'b0;
    idx     = '0;
    any_req = |req;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!done && req[idx]) begin
        win[idx] = 1'b1;
        done     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus with bounded bursts.
// Optional build macro TRI_BUS_TURNAROUND_EN inserts one all-Z cycle between
// owners; without it ownership hands over directly on the release edge.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int W         = W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       d,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 bus_valid,
  output tri   [W-1:0]         bus
);

  localparam int PW = $clog2(N);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_t        state, state_n;
  logic [N-1:0]  gnt_n;
  logic [PW-1:0] gnt_id_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] pick_ptr;
  logic [N-1:0]  win;
  logic [PW-1:0] win_id;
  logic          any_req;
  logic          rel;

  // On a release edge the expiring owner is already lowest priority, so the
  // picker sees the owner index rather than the stale pointer register.
  assign pick_ptr = (state == GRANT) ? gnt_id : ptr;
  assign rel      = (state == GRANT) && (!(|(req & gnt)) || (cnt == LAST_BEAT));

  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .win     (win),
    .any_req (any_req)
  );

  // Binary index of the picked winner
  always_comb begin
    win_id = '0;
    for (int i = 0; i < N; i++)
      if (win[i]) win_id = win_id | PW'(i);
  end

  // Next-state, next-grant and burst counter
  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    cnt_n    = cnt;
    ptr_n    = ptr;
    case (state)
      IDLE, TURN: begin
        cnt_n = '0;
        if (any_req) begin
          gnt_n    = win;
          gnt_id_n = win_id;
          state_n  = GRANT;
        end else begin
          gnt_n    = '0;
          gnt_id_n = '0;
          state_n  = IDLE;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_n = gnt_id;
          cnt_n = '0;
`ifdef TRI_BUS_TURNAROUND_EN
          gnt_n    = '0;
          gnt_id_n = '0;
          state_n  = TURN;
`else
          if (any_req) begin
            gnt_n    = win;
            gnt_id_n = win_id;
            state_n  = GRANT;
          end else begin
            gnt_n    = '0;
            gnt_id_n = '0;
            state_n  = IDLE;
          end
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        gnt_n    = '0;
        gnt_id_n = '0;
        cnt_n    = '0;
        state_n  = IDLE;
      end
    endcase
  end

  // State register; reset makes requester 0 highest priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      cnt    <= '0;
      ptr    <= PW'(N - 1);
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      gnt_id <= gnt_id_n;
      cnt    <= cnt_n;
      ptr    <= ptr_n;
    end
  end

  assign bus_valid = |gnt;

  // One tri-state driver per requester, enabled only by its grant bit
  for (genvar i = 0; i < N; i++) begin : g_drv
    assign bus = gnt[i] ? d[i*W +: W] : {W{1'bz}};
  end

endmodule
